// File: rtl/mileage_counter.sv
// Trip odometer for the taxi meter.
// Counts debounced wheel pulses into whole kilometres while a trip is active,
// flags the vehicle as stopped after a quiet period, and holds the final
// distance for the fare stage once the trip ends.
module mileage_counter #(
    parameter int PULSES_PER_KM = 100,
    parameter int DEBOUNCE      = 4,
    parameter int IDLE_TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        end_trip,
    input  logic        wheel_in,
    output logic [15:0] distance,
    output logic        trip_active,
    output logic        moving,
    output logic        km_tick
);

    localparam int PCW = (PULSES_PER_KM > 1) ? $clog2(PULSES_PER_KM) : 1;
    localparam int STW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int DBW = $clog2(DEBOUNCE + 1);

    localparam logic [PCW-1:0] PC_LAST  = PCW'(PULSES_PER_KM - 1);
    localparam logic [STW-1:0] ST_LAST  = STW'(IDLE_TIMEOUT - 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE - 1);
    localparam logic [15:0]    DIST_MAX = 16'hFFFF;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_STOPPED = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Distance never wraps: a full odometer simply stays at its maximum.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == DIST_MAX) ? v : v + 16'd1;
    endfunction

    function automatic logic at_max(input logic [15:0] v);
        return (v == DIST_MAX);
    endfunction

    logic           wheel_p0;
    logic           wheel_p1;
    logic           deb_lvl_p2;
    logic [DBW-1:0] deb_cnt_p2;
    logic           deb_rise;
    logic           wheel_edge_p3;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [PCW-1:0] pcnt;
    logic [PCW-1:0] pcnt_nxt;
    logic [STW-1:0] stall;
    logic [STW-1:0] stall_nxt;
    logic [15:0]    dist_nxt;
    logic           tick_nxt;

    // Stage p0/p1: two-flop synchronizer on the asynchronous wheel sensor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wheel_p0 <= 1'b0;
            wheel_p1 <= 1'b0;
        end else begin
            wheel_p0 <= wheel_in;
            wheel_p1 <= wheel_p0;
        end
    end

    // The debounced level rises when the synchronized wheel has been high
    // (while the level was low) for the final required cycle.
    assign deb_rise = wheel_p1 && !deb_lvl_p2 && (deb_cnt_p2 == DB_LAST);

    // Stage p2: accept a level change only after it has persisted long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_lvl_p2 <= 1'b0;
            deb_cnt_p2 <= '0;
        end else if (wheel_p1 == deb_lvl_p2) begin
            deb_cnt_p2 <= '0;
        end else if (deb_cnt_p2 == DB_LAST) begin
            deb_lvl_p2 <= wheel_p1;
            deb_cnt_p2 <= '0;
        end else begin
            deb_cnt_p2 <= deb_cnt_p2 + DBW'(1);
        end
    end

    // Stage p3: one-cycle strobe for each accepted rising wheel edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wheel_edge_p3 <= 1'b0;
        end else begin
            wheel_edge_p3 <= deb_rise;
        end
    end

    // Trip control: state transitions, pulse/km accounting and stall timing.
    always_comb begin
        state_nxt = state;
        dist_nxt  = distance;
        pcnt_nxt  = pcnt;
        stall_nxt = stall;
        tick_nxt  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    dist_nxt  = '0;
                    pcnt_nxt  = '0;
                    stall_nxt = '0;
                end
            end
            S_RUN, S_STOPPED: begin
                // Ending the trip takes priority; a coincident wheel edge is dropped.
                if (end_trip) begin
                    state_nxt = S_DONE;
                end else if (wheel_edge_p3) begin
                    state_nxt = S_RUN;
                    stall_nxt = '0;
                    if (pcnt == PC_LAST) begin
                        pcnt_nxt = '0;
                        tick_nxt = !at_max(distance);
                        dist_nxt = sat_inc(distance);
                    end else begin
                        pcnt_nxt = pcnt + PCW'(1);
                    end
                end else if (state == S_RUN) begin
                    if (stall == ST_LAST) begin
                        state_nxt = S_STOPPED;
                    end else begin
                        stall_nxt = stall + STW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Register state and all outputs so nothing reaches a port combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            distance    <= '0;
            pcnt        <= '0;
            stall       <= '0;
            km_tick     <= 1'b0;
            trip_active <= 1'b0;
            moving      <= 1'b0;
        end else begin
            state       <= state_nxt;
            distance    <= dist_nxt;
            pcnt        <= pcnt_nxt;
            stall       <= stall_nxt;
            km_tick     <= tick_nxt;
            trip_active <= (state_nxt == S_RUN) || (state_nxt == S_STOPPED);
            moving      <= (state_nxt == S_RUN);
        end
    end

endmodule

// File: tb/tb_mileage_counter.sv
// Directed bench for mileage_counter with a queue-based reference model
// compared against the DUT every cycle, plus literal checkpoints.
module tb_mileage_counter;

    localparam int PPK = 4;
    localparam int DEB = 2;
    localparam int TMO = 20;
    localparam logic [15:0] PRELOAD = 16'hFFF6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        end_trip = 1'b0;
    logic        wheel_in = 1'b0;
    logic [15:0] distance;
    logic        trip_active;
    logic        moving;
    logic        km_tick;

    int total = 0;
    int bad = 0;
    int dut_ticks = 0;
    int stall_drops = 0;
    bit chk_on = 1'b0;
    bit preload_req = 1'b0;

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_STOP, M_DONE} mstate_t;
    mstate_t     m_state = M_IDLE;
    logic [15:0] m_dist = 16'd0;
    bit          m_tick = 1'b0;
    int          m_pulses = 0;
    int          m_quiet = 0;
    bit          raw_q[$];
    bit          sync_win[$];
    bit          m_level = 1'b0;
    bit          m_pend = 1'b0;

    always #5 clk = ~clk;

    mileage_counter #(
        .PULSES_PER_KM(PPK),
        .DEBOUNCE(DEB),
        .IDLE_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .end_trip(end_trip),
        .wheel_in(wheel_in),
        .distance(distance),
        .trip_active(trip_active),
        .moving(moving),
        .km_tick(km_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_dist   = 16'd0;
        m_tick   = 1'b0;
        m_pulses = 0;
        m_quiet  = 0;
        raw_q    = '{1'b0, 1'b0};
        sync_win.delete();
        m_level  = 1'b0;
        m_pend   = 1'b0;
    endtask

    // Sensor path: raw sample seen two edges later; level flips once the last
    // DEB synchronized samples all disagree with it; a rise is usable next edge.
    task automatic model_step();
        bit edge_now;
        bit sync_now;
        bit all_diff;
        edge_now = m_pend;
        m_pend = 1'b0;
        sync_now = raw_q.pop_front();
        raw_q.push_back(wheel_in);
        sync_win.push_back(sync_now);
        if (sync_win.size() > DEB) void'(sync_win.pop_front());
        all_diff = (sync_win.size() == DEB);
        foreach (sync_win[i]) if (sync_win[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
            m_level = ~m_level;
            m_pend = m_level;
        end
        if (preload_req) m_dist = PRELOAD;
        m_tick = 1'b0;
        case (m_state)
            M_IDLE, M_DONE: begin
                if (start) begin
                    m_state = M_RUN;
                    m_dist = 16'd0;
                    m_pulses = 0;
                    m_quiet = 0;
                end
            end
            default: begin
                if (end_trip) begin
                    m_state = M_DONE;
                end else if (edge_now) begin
                    m_state = M_RUN;
                    m_quiet = 0;
                    m_pulses++;
                    if (m_pulses == PPK) begin
                        m_pulses = 0;
                        if (m_dist != 16'hFFFF) begin
                            m_dist++;
                            m_tick = 1'b1;
                        end
                    end
                end else if (m_state == M_RUN) begin
                    m_quiet++;
                    if (m_quiet == TMO) m_state = M_STOP;
                end
            end
        endcase
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        wheel_in = 1'b1;
        repeat (hi) @(negedge clk);
        wheel_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulses(input int n);
        repeat (n) pulse(5, 5);
    endtask

    task automatic strobe(input logic s, input logic e);
        start = s;
        end_trip = e;
        @(negedge clk);
        start = 1'b0;
        end_trip = 1'b0;
    endtask

    initial begin
        int t0;
        int s0;
        int lat;

        fork
            forever begin
                @(posedge clk or posedge rst);
                if (rst) model_reset();
                else model_step();
            end
            forever begin
                @(negedge clk);
                if (chk_on) begin
                    check("cycle", 32'({km_tick, trip_active, moving, distance}),
                          32'({m_tick, (m_state == M_RUN) || (m_state == M_STOP),
                               m_state == M_RUN, m_dist}));
                    if (km_tick) dut_ticks++;
                    if (trip_active && !moving) stall_drops++;
                end
            end
            begin
                #300000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "time limit exceeded");
            end
        join_none

        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        chk_on = 1'b1;
        cyc(2);
        check("rst_distance", 32'(distance), 32'(0));
        check("rst_active", 32'(trip_active), 32'(0));
        check("rst_moving", 32'(moving), 32'(0));
        check("rst_tick", 32'(km_tick), 32'(0));

        // Clean trip: 8 pulses = 2 km
        t0 = dut_ticks;
        s0 = stall_drops;
        strobe(1'b1, 1'b0);
        check("start_active", 32'(trip_active), 32'(1));
        check("start_moving", 32'(moving), 32'(1));
        pulses(8);
        check("clean_distance", 32'(distance), 32'(2));
        check("clean_model", 32'(m_dist), 32'(2));
        check("clean_ticks", 32'(dut_ticks - t0), 32'(2));
        check("clean_moving", 32'(stall_drops - s0), 32'(0));

        // Latency: km_tick on the 5th edge after wheel_in is first sampled high
        pulses(3);
        wheel_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (km_tick && lat == 0) lat = k;
        end
        @(negedge clk);
        wheel_in = 1'b0;
        cyc(5);
        check("latency", 32'(lat), 32'(5));
        check("latency_distance", 32'(distance), 32'(3));

        // Glitches only: no counting, vehicle flagged stopped
        repeat (5) pulse(1, 5);
        check("glitch_distance", 32'(distance), 32'(3));
        check("glitch_moving", 32'(moving), 32'(0));
        check("glitch_active", 32'(trip_active), 32'(1));

        // Resume from stopped; resume pulse counts toward the next km
        pulse(5, 5);
        check("resume_moving", 32'(moving), 32'(1));
        pulses(3);
        check("resume_distance", 32'(distance), 32'(4));
        strobe(1'b0, 1'b1);
        check("done_active", 32'(trip_active), 32'(0));
        check("done_moving", 32'(moving), 32'(0));
        pulses(50);
        check("done_hold", 32'(distance), 32'(4));

        // Simultaneous start/end_trip
        strobe(1'b1, 1'b0);
        check("restart_clear", 32'(distance), 32'(0));
        pulses(4);
        check("restart_distance", 32'(distance), 32'(1));
        strobe(1'b1, 1'b1);
        check("both_in_run_active", 32'(trip_active), 32'(0));
        check("both_in_run_dist", 32'(distance), 32'(1));
        strobe(1'b1, 1'b1);
        check("both_in_done_active", 32'(trip_active), 32'(1));
        check("both_in_done_dist", 32'(distance), 32'(0));

        // Saturation: preload near the top, then run past it
        #2;
        preload_req = 1'b1;
        force dut.distance = PRELOAD;
        @(posedge clk);
        #1;
        preload_req = 1'b0;
        @(negedge clk);
        #2;
        release dut.distance;
        @(negedge clk);
        pulses(32);
        check("preload_distance", 32'(distance), 32'hFFFE);
        t0 = dut_ticks;
        pulses(8);
        check("sat_distance", 32'(distance), 32'hFFFF);
        check("sat_model", 32'(m_dist), 32'hFFFF);
        check("sat_ticks", 32'(dut_ticks - t0), 32'(1));

        // Asynchronous reset mid-pulse
        strobe(1'b0, 1'b1);
        strobe(1'b1, 1'b0);
        pulses(12);
        check("pre_reset_distance", 32'(distance), 32'(3));
        wheel_in = 1'b1;
        cyc(2);
        #2;
        rst = 1'b1;
        #1;
        check("async_distance", 32'(distance), 32'(0));
        check("async_active", 32'(trip_active), 32'(0));
        check("async_moving", 32'(moving), 32'(0));
        check("async_tick", 32'(km_tick), 32'(0));
        @(negedge clk);
        wheel_in = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(3);
        check("post_reset_idle", 32'(trip_active), 32'(0));
        strobe(1'b1, 1'b0);
        pulses(4);
        check("post_reset_distance", 32'(distance), 32'(1));

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mileage_counter.md
MILEAGE_COUNTER -- requirements
Module: mileage_counter

Interface
REQ-001 Parameter PULSES_PER_KM, default 100: debounced wheel pulses per 1 km of distance.
REQ-002 Parameter DEBOUNCE, default 4: consecutive stable cycles needed for a synchronized wheel level change to be accepted.
REQ-003 Parameter IDLE_TIMEOUT, default 1000: cycles without a wheel edge before the vehicle is flagged stopped.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  trip start request, level-sampled.
REQ-007 end_trip  input  1  trip end request, level-sampled.
REQ-008 wheel_in  input  1  raw asynchronous wheel sensor pulse.
REQ-009 distance  output  16  trip distance in whole km; feeds the fare stage.
REQ-010 trip_active  output  1  high in RUN or STOPPED.
REQ-011 moving  output  1  high in RUN only; inverse drives the fare stage's no-charge input.
REQ-012 km_tick  output  1  one-cycle pulse on each distance increment.

Function
REQ-013 wheel_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounced level SHALL change only after the synchronized value has differed from it for DEBOUNCE consecutive cycles; wheel_edge SHALL be a one-cycle pulse on its 0->1 change.
REQ-015 States: IDLE, RUN, STOPPED, DONE; encoding is implementation-defined.
REQ-016 IDLE/DONE with start=1 -> RUN; distance, pulse counter and stall timer SHALL clear on the same edge.
REQ-017 RUN/STOPPED with end_trip=1 -> DONE; distance SHALL hold its value in DONE until the next start.
REQ-018 Simultaneous start and end_trip: start wins in IDLE/DONE; end_trip wins in RUN/STOPPED, where start is ignored.
REQ-019 In RUN/STOPPED, each wheel_edge SHALL increment the pulse counter (0..PULSES_PER_KM-1).
REQ-020 A wheel_edge at pulse count PULSES_PER_KM-1 SHALL wrap the counter to 0, increment distance and assert km_tick for that cycle.
REQ-021 distance SHALL saturate at 16'hFFFF; at saturation the pulse counter still wraps and km_tick SHALL NOT assert.
REQ-022 Stall timer SHALL clear on every wheel_edge and count otherwise in RUN; reaching IDLE_TIMEOUT-1 without an edge -> STOPPED.
REQ-023 STOPPED with wheel_edge -> RUN; that edge SHALL be counted per REQ-019/020.
REQ-024 A wheel_edge in the same cycle as a taken end_trip SHALL NOT be counted.
REQ-025 wheel_edge in IDLE or DONE SHALL be ignored.
REQ-026 Latency: with wheel_in rising and stable, distance/km_tick SHALL update on the (2+DEBOUNCE+1)-th rising clk edge after the first edge sampling wheel_in high.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, distance=0, trip_active=0, moving=0, km_tick=0, and clear pulse counter, stall timer, synchronizer and debounce state (debounced level=0).
REQ-029 Reset asserted mid-trip SHALL discard all trip state; after release the block waits in IDLE for start.
REQ-030 A wheel_in already high at reset release SHALL produce one wheel_edge after debounce; it is counted only if the block is in RUN/STOPPED by then.

Verification (PULSES_PER_KM=4, DEBOUNCE=2, IDLE_TIMEOUT=20)
REQ-031 start pulse, then 8 clean wheel pulses (high 5, low 5 cycles) -> distance=2, two km_tick pulses, moving=1 throughout.
REQ-032 In RUN, 1-cycle glitches on wheel_in every 6 cycles -> no wheel_edge, distance unchanged, STOPPED after 20 cycles, moving=0.
REQ-033 In STOPPED, one clean pulse -> RUN, pulse counter +1, moving=1; then end_trip -> DONE, trip_active=0, distance held across 50 further pulses.
REQ-034 start and end_trip high together in RUN -> DONE; again in DONE -> RUN with distance=0.
REQ-035 Preload distance to 16'hFFFE via 8 km of pulses after forcing, drive 8 more pulses -> distance=16'hFFFF, one km_tick only.
REQ-036 rst asserted mid-pulse in RUN with distance=3 -> all outputs 0 asynchronously; after release, start then 4 pulses -> distance=1.
